shift_add_mult_ctrl: RTL and testbench



---
 rtl/shift_add_mult_ctrl_pkg.sv | 16 +
 rtl/mult_sign_fix.sv | 14 +
 rtl/shift_add_mult_ctrl.sv | 144 ++++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier controller:
// default geometry and the sequencer state encoding.
package shift_add_mult_ctrl_pkg;

    localparam int MULT_WIDTH  = 32;
    localparam int MULT_CNT_W  = 5;
    localparam int MULT_PROD_W = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and for the
// final product sign correction.
module mult_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // |most-negative| stays as the same bit pattern, read back as unsigned.
    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the 32x32 shift-and-add multiplier: accept one operand pair,
// run WIDTH partial-product steps, apply sign correction, then present the product.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; in_ready is high only in IDLE, out_valid only in OUT, and the
    // producer holds its data stable until that transfer edge.
    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    product_q, product_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [PW-1:0]    acc_fixed;
    logic [PW-1:0]    partial;

    mult_sign_fix #(.W(WIDTH)) u_abs_a (
        .neg  (is_signed & op_a[WIDTH-1]),
        .din  (op_a),
        .dout (abs_a)
    );

    mult_sign_fix #(.W(WIDTH)) u_abs_b (
        .neg  (is_signed & op_b[WIDTH-1]),
        .din  (op_b),
        .dout (abs_b)
    );

    mult_sign_fix #(.W(PW)) u_prod_fix (
        .neg  (neg_q),
        .din  (acc_q),
        .dout (acc_fixed)
    );

    assign partial = mag_b_q[cnt_q] ? ({{WIDTH{1'b0}}, mag_a_q} << cnt_q) : '0;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        product_d   = product_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        neg_d       = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mag_a_d    = abs_a;
                    mag_b_d    = abs_b;
                    neg_d      = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + partial;
                // Counter parks on the last step so it can never wrap into an extra add.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                product_d   = acc_fixed;
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            product_q   <= product_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            neg_q       <= neg_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed vector table, reset
// abort, back-to-back streaming and randomized operands against an arithmetic model.
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_checks;
    int n_errors;
    logic [63:0] exp_q[$];

    shift_add_mult_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference model: plain integer multiplication of the operands as read.
    function automatic logic [63:0] ref_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with junk traffic on the inputs while busy.
    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold);
        int k;
        bit busy_ok;
        bit rdy_ok;
        bit stable_ok;
        logic [63:0] held;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        exp_q.push_back(exp);
        tick();
        k       = 0;
        busy_ok = 1'b1;
        rdy_ok  = 1'b1;
        while (!out_valid && k < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (in_ready) rdy_ok = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            is_signed = 1'($urandom_range(0, 1));
            op_a      = $urandom;
            op_b      = $urandom;
            tick();
            k++;
        end
        if (k >= 100) begin
            check("out_valid_timeout", 64'(out_valid), 64'd1);
            void'(exp_q.pop_back());
            in_valid  = 1'b0;
            out_ready = 1'b0;
            return;
        end
        check("latency", 64'(k), 64'd33);
        check("busy_while_running", 64'(busy_ok), 64'd1);
        check("in_ready_low_while_running", 64'(rdy_ok), 64'd1);
        check("busy_low_in_out", 64'(busy), 64'd0);
        check("product", product, exp_q.pop_front());
        held      = product;
        stable_ok = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = $urandom;
            tick();
            if (!out_valid || product !== held || in_ready) stable_ok = 1'b0;
        end
        check("hold_stable", 64'(stable_ok), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_handshake", 64'(out_valid), 64'd0);
        check("in_ready_after_handshake", 64'(in_ready), 64'd1);
        check("product_held_in_idle", product, held);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;

        vecs[0] = '{1'b0, 32'd3,        32'd5,        64'h0000_0000_0000_000F, 5};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 3};
        vecs[6] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_product", product, 64'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
        end

        // Reset in the middle of RUN discards the operation
        is_signed = 1'b0;
        op_a      = 32'd1000;
        op_b      = 32'd1000;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("busy_before_abort", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        begin
            bit quiet;
            quiet = 1'b1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid || busy) quiet = 1'b0;
            end
            check("abort_no_result", 64'(quiet), 64'd1);
        end
        do_op(1'b0, 32'd6, 32'd7, 64'h2A, 0);

        // Back-to-back: in_valid and out_ready both held high
        begin
            logic [31:0] ba[3];
            logic [31:0] bb[3];
            int n_acc;
            int n_done;
            int cyc;
            int last_hs;
            bit acc_now;
            bit hs_now;
            bit quiet;
            ba[0] = 32'd11;          bb[0] = 32'd13;
            ba[1] = 32'hDEAD_BEEF;   bb[1] = 32'h0000_0100;
            ba[2] = 32'h0001_0000;   bb[2] = 32'h0001_0000;
            n_acc   = 0;
            n_done  = 0;
            cyc     = 0;
            last_hs = 0;
            is_signed = 1'b0;
            op_a      = ba[0];
            op_b      = bb[0];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (n_done < 3 && cyc < 400) begin
                acc_now = in_valid && in_ready;
                hs_now  = out_valid && out_ready;
                if (hs_now) begin
                    check("b2b_product", product, exp_q.pop_front());
                    last_hs = cyc;
                end
                if (acc_now) begin
                    if (n_acc > 0) check("b2b_idle_gap", 64'(cyc - last_hs), 64'd1);
                    exp_q.push_back(ref_mult(1'b0, op_a, op_b));
                    n_acc++;
                end
                tick();
                cyc++;
                if (acc_now) begin
                    if (n_acc < 3) begin
                        op_a = ba[n_acc];
                        op_b = bb[n_acc];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (hs_now) begin
                    n_done++;
                    check("b2b_in_ready_after_hs", 64'(in_ready), 64'd1);
                    check("b2b_out_valid_after_hs", 64'(out_valid), 64'd0);
                end
            end
            check("b2b_results", 64'(n_done), 64'd3);
            check("b2b_accepts", 64'(n_acc), 64'd3);
            check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
            quiet = 1'b1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid) quiet = 1'b0;
            end
            check("b2b_no_duplicate", 64'(quiet), 64'd1);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            exp_q.delete();
        end

        // Randomized operands against the arithmetic model
        for (int n = 0; n < 16; n++) begin
            logic        s;
            logic [31:0] a;
            logic [31:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h0000_0000;
                3: b = 32'h7FFF_FFFF;
                default: ;
            endcase
            do_op(s, a, b, ref_mult(s, a, b), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
